// File: rtl/add_ioq_header_pkg.sv
// ============================================================================
// add_ioq_header_pkg : IOQ module-header field layout and valid-byte decode
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package add_ioq_header_pkg;

    localparam int IOQ_FIELD_W      = 16;
    localparam int IOQ_BYTE_LEN_LSB = 0;
    localparam int IOQ_SRC_PORT_LSB = 16;
    localparam int IOQ_WORD_LEN_LSB = 32;
    localparam int IOQ_DST_PORT_LSB = 48;

    typedef enum logic [0:0] {
        IN_ACCEPT = 1'b0,
        IN_DROP   = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_HDR  = 2'd1,
        OUT_BODY = 2'd2
    } out_state_t;

    // Lowest set ctrl bit marks the last valid byte: bit0 -> 8 bytes, bit7 -> 1.
    function automatic logic [3:0] valid_bytes(input logic [7:0] ctrl);
        logic [3:0] vb;
        vb = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ctrl[i]) vb = 4'(8 - i);
        end
        return vb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_ioq_header_pkt_fifo.sv
// ============================================================================
// add_ioq_header_pkt_fifo : synchronous FIFO with show-ahead read and packet
//                           commit/rewind on the write side
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module add_ioq_header_pkt_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             rewind,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] cptr;
    logic [ADDR_WIDTH:0] rptr;
    logic do_wr;
    logic do_rd;

    // Full counts in-flight words; empty only looks at committed ones.
    assign full    = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign empty   = (rptr == cptr);
    assign do_wr   = wr_en && !full && !rewind;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            cptr <= '0;
            rptr <= '0;
        end else begin
            if (rewind) begin
                wptr <= cptr;
            end else if (do_wr) begin
                wptr <= wptr + 1'b1;
                if (commit) cptr <= wptr + 1'b1;
            end
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/add_ioq_header.sv
// ============================================================================
// add_ioq_header : store-and-forward stage prefixing each packet with an IOQ
//                  module header carrying its word and byte length
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module add_ioq_header
    import add_ioq_header_pkg::*;
#(
    parameter int                    DATA_WIDTH          = 64,
    parameter int                    CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int                    UDP_REG_SRC_WIDTH   = 2,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM       = `IO_QUEUE_STAGE_NUM,
    parameter logic [15:0]           SRC_PORT            = 16'd0,
    parameter int                    BUF_ADDR_WIDTH      = 9,
    parameter int                    LEN_FIFO_ADDR_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [CTRL_WIDTH-1:0]           in_ctrl,
    input  logic                            in_wr,
    output logic                            in_rdy,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [CTRL_WIDTH-1:0]           out_ctrl,
    output logic                            out_wr,
    input  logic                            out_rdy,
    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);

    localparam int          BUF_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [15:0] BUF_DEPTH = 16'(1 << BUF_ADDR_WIDTH);

    assign reg_req_out     = reg_req_in;
    assign reg_ack_out     = reg_ack_in;
    assign reg_rd_wr_L_out = reg_rd_wr_L_in;
    assign reg_addr_out    = reg_addr_in;
    assign reg_data_out    = reg_data_in;
    assign reg_src_out     = reg_src_in;

    in_state_t       in_state, in_state_next;
    logic [15:0]     word_cnt, word_cnt_next;
    logic            in_last, oversize, dropping;
    logic            buf_wr, len_wr, buf_rd, len_rd;
    logic            buf_full, buf_empty, len_full, len_empty;
    logic [15:0]     byte_len_in;
    logic [BUF_WIDTH-1:0] buf_rd_data;
    logic [31:0]     len_rd_data;

    assign in_last     = (in_ctrl != '0);
    // A packet that has filled the whole buffer on its own can never commit.
    assign oversize    = (in_state == IN_ACCEPT) && (word_cnt == BUF_DEPTH);
    assign dropping    = (in_state == IN_DROP) || oversize;
    assign in_rdy      = !len_full && (!buf_full || dropping);
    assign buf_wr      = in_wr && !dropping;
    assign len_wr      = buf_wr && in_last;
    assign byte_len_in = {word_cnt[12:0], 3'b000} + {12'd0, valid_bytes(8'(in_ctrl))};

    always_comb begin
        in_state_next = in_state;
        word_cnt_next = word_cnt;
        case (in_state)
            IN_ACCEPT: begin
                if (oversize) begin
                    word_cnt_next = '0;
                    in_state_next = (in_wr && in_last) ? IN_ACCEPT : IN_DROP;
                end else if (in_wr) begin
                    word_cnt_next = in_last ? 16'd0 : word_cnt + 16'd1;
                end
            end
            IN_DROP: begin
                if (in_wr && in_last) in_state_next = IN_ACCEPT;
            end
            default: in_state_next = IN_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state <= IN_ACCEPT;
            word_cnt <= '0;
        end else begin
            in_state <= in_state_next;
            word_cnt <= word_cnt_next;
        end
    end

    add_ioq_header_pkt_fifo #(
        .WIDTH      (BUF_WIDTH),
        .ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_data_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr),
        .wr_data ({in_ctrl, in_data}),
        .commit  (in_last),
        .rewind  (oversize),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    add_ioq_header_pkt_fifo #(
        .WIDTH      (32),
        .ADDR_WIDTH (LEN_FIFO_ADDR_WIDTH)
    ) u_len_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (len_wr),
        .wr_data ({word_cnt + 16'd1, byte_len_in}),
        .commit  (1'b1),
        .rewind  (1'b0),
        .rd_en   (len_rd),
        .rd_data (len_rd_data),
        .full    (len_full),
        .empty   (len_empty)
    );

    out_state_t            out_state, out_state_next;
    logic [15:0]           hdr_word_len, hdr_byte_len;
    logic [DATA_WIDTH-1:0] out_data_next;
    logic [CTRL_WIDTH-1:0] out_ctrl_next;
    logic                  out_wr_next;

    always_comb begin
        out_state_next = out_state;
        len_rd         = 1'b0;
        buf_rd         = 1'b0;
        out_wr_next    = 1'b0;
        out_data_next  = out_data;
        out_ctrl_next  = out_ctrl;
        case (out_state)
            OUT_IDLE: begin
                if (!len_empty && out_rdy) begin
                    len_rd         = 1'b1;
                    out_state_next = OUT_HDR;
                end
            end
            OUT_HDR: begin
                if (out_rdy) begin
                    out_wr_next   = 1'b1;
                    out_ctrl_next = IOQ_STAGE_NUM;
                    out_data_next = '0;
                    out_data_next[IOQ_WORD_LEN_LSB +: IOQ_FIELD_W] = hdr_word_len;
                    out_data_next[IOQ_SRC_PORT_LSB +: IOQ_FIELD_W] = SRC_PORT;
                    out_data_next[IOQ_BYTE_LEN_LSB +: IOQ_FIELD_W] = hdr_byte_len;
                    out_state_next = OUT_BODY;
                end
            end
            OUT_BODY: begin
                if (out_rdy && !buf_empty) begin
                    buf_rd        = 1'b1;
                    out_wr_next   = 1'b1;
                    out_data_next = buf_rd_data[DATA_WIDTH-1:0];
                    out_ctrl_next = buf_rd_data[BUF_WIDTH-1 -: CTRL_WIDTH];
                    if (buf_rd_data[BUF_WIDTH-1 -: CTRL_WIDTH] != '0) out_state_next = OUT_IDLE;
                end
            end
            default: out_state_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state    <= OUT_IDLE;
            hdr_word_len <= '0;
            hdr_byte_len <= '0;
            out_wr       <= 1'b0;
            out_data     <= '0;
            out_ctrl     <= '0;
        end else begin
            out_state <= out_state_next;
            if (len_rd) {hdr_word_len, hdr_byte_len} <= len_rd_data;
            out_wr   <= out_wr_next;
            out_data <= out_data_next;
            out_ctrl <= out_ctrl_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add_ioq_header.sv
// ============================================================================
// tb_add_ioq_header : directed bench with a packet-level scoreboard model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_add_ioq_header;

    localparam int          BUF_AW = 5;
    localparam int          DEPTH  = 1 << BUF_AW;
    localparam logic [15:0] SRC    = 16'h00A5;
    localparam logic [7:0]  STAGE  = 8'hff;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;

    logic                            reg_req_in = 1'b1;
    logic                            reg_ack_in = 1'b0;
    logic                            reg_rd_wr_L_in = 1'b1;
    logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in = 23'h12345;
    logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in = 32'hCAFEF00D;
    logic [1:0]                      reg_src_in = 2'b10;
    logic                            reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [1:0]                      reg_src_out;

    int    tests = 0;
    int    fails = 0;
    int    out_count = 0;
    int    first_run = 0;
    int    pkt_id = 0;
    bit    toggle_en = 1'b0;
    bit    rdy_level = 1'b1;
    word_t exp_q[$];
    logic [63:0] hdr_log[$];

    add_ioq_header #(
        .SRC_PORT       (SRC),
        .BUF_ADDR_WIDTH (BUF_AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_wr          (out_wr),
        .out_rdy         (out_rdy),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Header the packet must carry, derived directly from length and last ctrl.
    function automatic logic [63:0] model_hdr(input int len, input logic [7:0] last_ctrl);
        int vb;
        vb = 0;
        for (int i = 0; i < 8; i++) begin
            if (last_ctrl[i]) begin
                vb = 8 - i;
                break;
            end
        end
        return {16'h0000, 16'(len), SRC, 16'(8 * (len - 1) + vb)};
    endfunction

    function automatic logic [63:0] hdr_at(input int k);
        return (k < hdr_log.size()) ? hdr_log[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_rdy = toggle_en ? !out_rdy : rdy_level;
        end
    end

    // Scoreboard: every emitted word is checked against the model queue.
    initial begin
        bit    rdy_now;
        int    run;
        word_t e;
        run = 0;
        forever begin
            @(posedge clk);
            rdy_now = out_rdy;
            #1;
            if (out_wr) begin
                out_count++;
                run++;
                tests++;
                if (!rdy_now) begin
                    fails++;
                    $display("FAIL stall_rule: out_wr=1 after out_rdy=0");
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got ctrl=%h data=%h, expected none", out_ctrl, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_ctrl !== e.ctrl || out_data !== e.data) begin
                        fails++;
                        $display("FAIL out_word: got ctrl=%h data=%h expected ctrl=%h data=%h",
                                 out_ctrl, out_data, e.ctrl, e.data);
                    end
                end
                if (out_ctrl == STAGE) hdr_log.push_back(out_data);
            end else begin
                if (run != 0 && first_run == 0) first_run = run;
                run = 0;
            end
        end
    end

    task automatic send_pkt(input int len, input logic [7:0] last_ctrl, input bit check_rdy);
        word_t w;
        int    guard;
        logic [63:0] d[$];
        pkt_id++;
        for (int i = 0; i < len; i++) d.push_back({16'(pkt_id), 16'(i), 32'($urandom())});
        if (len <= DEPTH) begin
            w.ctrl = STAGE;
            w.data = model_hdr(len, last_ctrl);
            exp_q.push_back(w);
            for (int i = 0; i < len; i++) begin
                w.ctrl = (i == len - 1) ? last_ctrl : 8'h00;
                w.data = d[i];
                exp_q.push_back(w);
            end
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (check_rdy) check("in_rdy_during_drop", 64'(in_rdy), 64'd1);
            guard = 0;
            while (!in_rdy && guard < 500) begin
                in_wr = 1'b0;
                @(negedge clk);
                guard++;
            end
            if (!in_rdy) begin
                tests++;
                fails++;
                $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1 within 500 cycles");
                in_wr = 1'b0;
                return;
            end
            in_wr   = 1'b1;
            in_data = d[i];
            in_ctrl = (i == len - 1) ? last_ctrl : 8'h00;
        end
        @(negedge clk);
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int guard;

        repeat (3) @(negedge clk);
        check("reset_out_wr",   64'(out_wr), 64'd0);
        check("reset_out_data", out_data,    64'd0);
        check("reset_out_ctrl", 64'(out_ctrl), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_rdy", 64'(in_rdy), 64'd1);

        check("reg_req",  64'(reg_req_out),     64'd1);
        check("reg_ack",  64'(reg_ack_out),     64'd0);
        check("reg_rdwr", 64'(reg_rd_wr_L_out), 64'd1);
        check("reg_addr", 64'(reg_addr_out),    64'h12345);
        check("reg_data", 64'(reg_data_out),    64'hCAFEF00D);
        check("reg_src",  64'(reg_src_out),     64'd2);

        send_pkt(3, 8'h01, 1'b0);
        drain();
        check("first_burst_len", 64'(first_run), 64'd4);
        send_pkt(1, 8'h80, 1'b0);
        drain();
        send_pkt(2, 8'h04, 1'b0);
        drain();
        check("hdr_count", 64'(hdr_log.size()), 64'd3);
        check("hdr_3w_0x01", hdr_at(0), 64'h0000_0003_00A5_0018);
        check("hdr_1w_0x80", hdr_at(1), 64'h0000_0001_00A5_0001);
        check("hdr_2w_0x04", hdr_at(2), 64'h0000_0002_00A5_000E);

        toggle_en = 1'b1;
        send_pkt(10, 8'h02, 1'b0);
        drain();
        toggle_en = 1'b0;
        rdy_level = 1'b1;
        repeat (2) @(negedge clk);

        send_pkt(DEPTH, 8'h01, 1'b0);
        drain();
        send_pkt(DEPTH + 4, 8'h10, 1'b1);
        send_pkt(2, 8'h20, 1'b1);
        drain();

        rdy_level = 1'b0;
        repeat (3) @(negedge clk);
        base = out_count;
        for (int k = 0; k < 7; k++) send_pkt(2, 8'h08, 1'b0);
        check("in_rdy_len7", 64'(in_rdy), 64'd1);
        send_pkt(2, 8'h08, 1'b0);
        check("in_rdy_len8", 64'(in_rdy), 64'd0);
        check("held_no_output", 64'(out_count), 64'(base));
        rdy_level = 1'b1;
        send_pkt(2, 8'h40, 1'b0);
        drain();

        base = out_count;
        send_pkt(10, 8'h01, 1'b0);
        guard = 0;
        while (out_count < base + 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_output_started", 64'(out_count >= base + 3), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_out_wr",   64'(out_wr), 64'd0);
        check("reset_mid_out_data", out_data,    64'd0);
        reset = 1'b0;
        @(negedge clk);
        send_pkt(3, 8'h01, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
